// File: rtl/timestamp_grey_counter_pkg.sv
// Shared definitions for the timestamp Gray counter: FSM state encoding and the
// binary-to-Gray helper used by models that need the same encoding.
package ts_grey_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } ts_state_e;

    localparam int GREY_MAX_WIDTH = 64;

    // Callers narrower than GREY_MAX_WIDTH zero-extend in and truncate out.
    function automatic logic [GREY_MAX_WIDTH-1:0] bin_to_grey(
        input logic [GREY_MAX_WIDTH-1:0] value
    );
        return value ^ (value >> 1);
    endfunction

endpackage

// File: rtl/timestamp_grey_counter_binary_to_grey.sv
// Combinational binary-to-Gray encoder; counterpart of the receiver's
// Gray-to-binary decoder.
module binary_to_grey #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] grey
);

    assign grey = binary ^ (binary >> 1);

endmodule

// File: rtl/timestamp_grey_counter.sv
// Timestamp counter with registered Gray output for cross-domain sampling and a
// guarded reload. Optional out_binary port enabled by TS_GREY_BINARY_OUT_EN.
//
// state     | meaning
// ST_RUN    | counting on count_en, load_req accepted
// ST_LOAD   | one cycle: held value written to counter, load_ack follows
// ST_SETTLE | counter frozen, out_valid low while receiver synchronizer flushes
module timestamp_grey_counter
    import ts_grey_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ack,
    output logic             busy,
    output logic [WIDTH-1:0] out_grey,
    output logic             out_valid
`ifdef TS_GREY_BINARY_OUT_EN
    ,
    output logic [WIDTH-1:0] out_binary
`endif
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    ts_state_e        state, state_nxt;
    logic [WIDTH-1:0] counter, counter_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic [WIDTH-1:0] grey_nxt;
    logic [SW-1:0]    settle, settle_nxt;
    logic             valid_nxt;
    logic             ack_nxt;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        hold_nxt    = hold;
        settle_nxt  = settle;
        valid_nxt   = out_valid;
        ack_nxt     = 1'b0;
        case (state)
            ST_RUN: begin
                // A coincident increment is dropped so the load lands cleanly.
                if (load_req) begin
                    hold_nxt  = load_value;
                    valid_nxt = 1'b0;
                    state_nxt = ST_LOAD;
                end else if (count_en) begin
                    counter_nxt = counter + WIDTH'(1);
                end
            end
            ST_LOAD: begin
                counter_nxt = hold;
                ack_nxt     = 1'b1;
                settle_nxt  = SETTLE_INIT;
                state_nxt   = ST_SETTLE;
            end
            ST_SETTLE: begin
                valid_nxt = 1'b0;
                if (settle == '0) begin
                    state_nxt = ST_RUN;
                    valid_nxt = 1'b1;
                end else begin
                    settle_nxt = settle - SW'(1);
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Encoding the next value keeps out_grey aligned with the counter register.
    binary_to_grey #(
        .WIDTH(WIDTH)
    ) u_binary_to_grey (
        .binary(counter_nxt),
        .grey  (grey_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SETTLE;
            counter   <= '0;
            hold      <= '0;
            settle    <= SETTLE_INIT;
            out_grey  <= '0;
            out_valid <= 1'b0;
            load_ack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            hold      <= hold_nxt;
            settle    <= settle_nxt;
            out_grey  <= grey_nxt;
            out_valid <= valid_nxt;
            load_ack  <= ack_nxt;
        end
    end

    assign busy = (state != ST_RUN);

`ifdef TS_GREY_BINARY_OUT_EN
    assign out_binary = counter;
`endif

endmodule

// File: tb/tb_timestamp_grey_counter.sv
// Scoreboard bench for timestamp_grey_counter (WIDTH=8, SETTLE_CYCLES=4):
// directed steps push expected outputs, a monitor pops and compares each cycle.
module tb_timestamp_grey_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       count_en;
    logic       load_req;
    logic [7:0] load_value;
    logic       load_ack;
    logic       busy;
    logic [7:0] out_grey;
    logic       out_valid;
`ifdef TS_GREY_BINARY_OUT_EN
    logic [7:0] out_binary;
`endif

    typedef struct packed {
        logic [7:0] grey;
        logic [7:0] bin;
        logic       valid;
        logic       ack;
        logic       busy;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_step = 0;
    logic [7:0] gtab [0:16];

    always #5 clk = ~clk;

    timestamp_grey_counter #(
        .WIDTH(8),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_en  (count_en),
        .load_req  (load_req),
        .load_value(load_value),
        .load_ack  (load_ack),
        .busy      (busy),
        .out_grey  (out_grey),
        .out_valid (out_valid)
`ifdef TS_GREY_BINARY_OUT_EN
        ,
        .out_binary(out_binary)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s step %0d t=%0t: got %h required %h", name, n_step, $time, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled 1ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_step++;
                chk("out_grey",  out_grey,         e.grey);
                chk("out_valid", {7'd0, out_valid}, {7'd0, e.valid});
                chk("load_ack",  {7'd0, load_ack},  {7'd0, e.ack});
                chk("busy",      {7'd0, busy},      {7'd0, e.busy});
`ifdef TS_GREY_BINARY_OUT_EN
                chk("out_binary", out_binary, e.bin);
`endif
            end
        end
    end

    task automatic step(input logic r, input logic ce, input logic lr, input logic [7:0] lv,
                        input logic [7:0] eg, input logic [7:0] eb,
                        input logic ev, input logic ea, input logic ebz);
        exp_t x;
        reset      = r;
        count_en   = ce;
        load_req   = lr;
        load_value = lv;
        x.grey  = eg;
        x.bin   = eb;
        x.valid = ev;
        x.ack   = ea;
        x.busy  = ebz;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        gtab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C,
                 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08, 8'h18};

        // reset state
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);

        // reset release with count_en held: ignored while settling
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        step(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        // ten increments
        for (int i = 1; i <= 10; i++) step(0, 1, 0, 8'h00, gtab[i], 8'(i), 1, 0, 0);
        step(0, 0, 0, 8'h00, 8'h0F, 8'h0A, 1, 0, 0);

        // load 0xFE; load_value changes during LOAD without effect
        step(0, 0, 1, 8'hFE, 8'h0F, 8'h0A, 0, 0, 1);
        step(0, 0, 1, 8'h33, 8'h81, 8'hFE, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h81, 8'hFE, 0, 0, 1);
        step(0, 0, 0, 8'h00, 8'h81, 8'hFE, 1, 0, 0);

        // wrap 0xFE -> 0xFF -> 0x00
        step(0, 1, 0, 8'h00, 8'h80, 8'hFF, 1, 0, 0);
        step(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);

        // count to 0x10
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 8'h00, gtab[i], 8'(i), 1, 0, 0);

        // load 0x40 with coincident count_en; load_req pulse and count_en in SETTLE
        step(0, 1, 1, 8'h40, 8'h18, 8'h10, 0, 0, 1);
        step(0, 1, 1, 8'h55, 8'h60, 8'h40, 0, 1, 1);
        step(0, 1, 1, 8'h99, 8'h60, 8'h40, 0, 0, 1);
        step(0, 1, 0, 8'h00, 8'h60, 8'h40, 0, 0, 1);
        step(0, 1, 0, 8'h00, 8'h60, 8'h40, 0, 0, 1);
        step(0, 0, 0, 8'h00, 8'h60, 8'h40, 1, 0, 0);
        step(0, 0, 0, 8'h00, 8'h60, 8'h40, 1, 0, 0);

        // reset during LOAD: no ack, full reset state
        step(0, 0, 1, 8'h22, 8'h60, 8'h40, 0, 0, 1);
        step(1, 0, 0, 8'h22, 8'h00, 8'h00, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        step(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        step(0, 1, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);
        step(0, 0, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);

        @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timestamp_grey_counter.md
Name: timestamp_grey_counter

Overview:
- Sample-timestamp counter for the upack timestamp path. Produces a registered Gray-coded count so another clock domain can sample it safely through a multi-flop synchronizer.
- The receiving side decodes the count back to binary with the existing Gray-to-binary converter.
- Supports a software-initiated reload. A reload is guarded by a validity window so the receiver discards the multi-bit jump.

Parameters:
- WIDTH, 32, counter and timestamp width in bits (min 2).
- SETTLE_CYCLES, 4, number of clk cycles out_valid stays low after a reload or reset. Must cover the receiver's synchronizer depth plus margin. Min 1.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- count_en  in  1  sample strobe; counter advances by exactly 1 per cycle when high
- load_req  in  1  request to load load_value; level-sampled, accepted only when busy=0
- load_value  in  WIDTH  new binary timestamp, captured in the accept cycle
- load_ack  out  1  one-cycle pulse when load_value has been written to the counter
- busy  out  1  high whenever state != RUN
- out_grey  out  WIDTH  registered Gray code of the internal binary counter
- out_valid  out  1  high when out_grey is a monotonic, single-bit-step sequence

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (port reset). All state changes occur on the rising edge of clk.
- Reset values: counter=0, out_grey=0, out_valid=0, load_ack=0, busy=1, state=SETTLE, settle counter=SETTLE_CYCLES-1.
- Gray encoding: out_grey <= next ^ (next >> 1), registered from the next-counter value. out_grey therefore matches the counter in the same cycle with no extra lag.
- Latency: count_en high in cycle k makes out_grey show gray(old+1) from cycle k+1.
- Wrap: 2^WIDTH-1 -> 0 modulo 2^WIDTH. gray(max)={1,0...0} -> 0 is a single-bit change. out_valid stays high across the wrap.
- Increment is fixed at 1. No other step size is allowed, because it would break the Gray property.
- State RUN:
  - count_en=1 increments the counter.
  - load_req=1 captures load_value into a holding register. out_valid <= 0 and state -> LOAD. The counter is held.
  - If count_en and load_req are high together, load wins and that increment is dropped.
- State LOAD (exactly 1 cycle):
  - counter <= held value; out_grey <= gray(held value); load_ack <= 1 (asserted the following cycle).
  - Settle counter <= SETTLE_CYCLES-1; state -> SETTLE.
- State SETTLE:
  - Counter frozen; count_en ignored; out_valid=0.
  - The settle counter decrements each cycle. When it is 0, state -> RUN and out_valid <= 1.
- load_req while busy=1 is ignored (not queued). Requesters hold load_req until load_ack.
- Guarantee: out_valid low-to-high occurs at least SETTLE_CYCLES cycles after the last multi-bit out_grey change.
- Reset mid-load: discards the pending load, no load_ack is issued, and all reset values apply.
- load_value may change freely after the accept cycle.

Optional Feature:
- Macro: TS_GREY_BINARY_OUT_EN.
- Defined: adds port out_binary (out, WIDTH), a registered binary counter value cycle-aligned with out_grey, for same-domain consumers. Reset value is 0.
- Undefined: the port is absent. The counter remains internal and behaviour is otherwise identical.

Decomposition:
- Package ts_grey_pkg holds:
  - state encoding constants ST_RUN, ST_LOAD, ST_SETTLE (2-bit);
  - function bin_to_grey(value), shared with bench models.
- One natural sub-module: binary_to_grey, a purely combinational WIDTH-parameterised encoder. It is the counterpart of the existing decoder and is instantiated once on the next-counter value.

Test Plan (WIDTH=8, SETTLE_CYCLES=4):
- Reset release: out_valid=0 for 4 cycles then 1; out_grey=0x00; busy falls together with out_valid rising.
- count_en held 10 cycles: out_grey sequence 0x01,0x03,0x02,0x06,0x07,0x05,0x04,0x0C,0x0D,0x0F; each step differs by exactly 1 bit.
- Wrap: load 0xFE, settle, 2 count_en pulses: out_grey 0x81 -> 0x80 -> 0x00; out_valid stays 1 across the wrap.
- Load with coincident count_en at counter=0x10, load_value=0x40: counter is not 0x11; load_ack one cycle; out_grey=0x60; out_valid low exactly 5 cycles (LOAD + 4 SETTLE).
- load_req pulse during SETTLE and count_en during SETTLE: both ignored; counter unchanged; no second load_ack.
- Reset asserted in LOAD cycle: no load_ack; out_grey=0x00, out_valid=0 next cycle. With TS_GREY_BINARY_OUT_EN, out_binary=0 and tracks gray-decoded out_grey thereafter.
